slave_axi_write_slave: RTL and testbench

- Parametrised successor to the single-burst AXI write-channel front end. Accepts one AW burst at a time and generates the per-beat address for FIXED, INCR and WRAP bursts.
- Streams beats to the bridge engine over a valid/ready beat interface, then returns a B response that merges locally detected protocol errors with the engine's completion code.
- Sits between the external AXI master and the APB engine.

---
 rtl/bridge_utils_pkg.sv | 38 +++
 rtl/axi_burst_addr_gen.sv | 36 +++
 rtl/slave_axi_write_slave.sv | 200 ++++++++++++++++++++
 tb/tb_slave_axi_write_slave.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_utils_pkg.sv
// Shared types for the AXI-to-APB bridge: burst encodings, response codes,
// the captured AW descriptor and the write front-end state encoding.
package bridge_utils;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Descriptor fields are sized for the widest supported configuration
    localparam int MAX_ID_WIDTH   = 16;
    localparam int MAX_ADDR_WIDTH = 64;
    localparam int MAX_LEN_WIDTH  = 8;

    typedef struct packed {
        logic [MAX_ID_WIDTH-1:0]   id;
        logic [MAX_ADDR_WIDTH-1:0] addr;
        logic [MAX_LEN_WIDTH-1:0]  len;
        logic [2:0]                size;
        burst_t                    burst;
    } aw_info_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_DATA      = 2'b01,
        S_RESP_WAIT = 2'b10,
        S_B         = 2'b11
    } wr_state_t;

    function automatic logic wrap_len_ok(input logic [MAX_LEN_WIDTH-1:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address for FIXED, INCR and WRAP bursts.
// Shared between the write front end and the read side.
module axi_burst_addr_gen
    import bridge_utils::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [LEN_WIDTH-1:0]  len,
    input  burst_t                burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step_s;
    logic [ADDR_WIDTH-1:0] incr_addr_s;
    logic [ADDR_WIDTH-1:0] wrap_mask_s;

    assign step_s      = ADDR_WIDTH'(1'b1) << size;
    assign incr_addr_s = addr + step_s;
    // Window is (len+1) beats; len is a power of two minus one for legal WRAP bursts
    assign wrap_mask_s = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1'b1)) << size) - ADDR_WIDTH'(1'b1);

    // Select the advance rule for the burst type
    always_comb begin
        next_addr = addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr_addr_s;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask_s) | (incr_addr_s & wrap_mask_s);
            default:     next_addr = addr;
        endcase
    end

endmodule

// File: rtl/slave_axi_write_slave.sv
// AXI write-channel front end: one burst at a time, beats streamed to the engine,
// B response merges local errors with the engine code. Option: SLAVE_AXI_WLAST_CHECK_EN.
module slave_axi_write_slave
    import bridge_utils::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [LEN_WIDTH-1:0]    awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    output logic                    beat_valid,
    input  logic                    beat_ready,
    output logic [ADDR_WIDTH-1:0]   beat_addr,
    output logic [DATA_WIDTH-1:0]   beat_data,
    output logic [DATA_WIDTH/8-1:0] beat_strb,
    output logic                    beat_last,
    input  logic                    eng_resp_valid,
    output logic                    eng_resp_ready,
    input  logic [1:0]              eng_resp
);

    localparam int         STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0] MAX_SIZE   = 3'($clog2(STRB_WIDTH));

    wr_state_t             state_r;
    wr_state_t             state_nxt_s;
    aw_info_t              aw_r;
    logic [LEN_WIDTH-1:0]  cnt_r;
    logic                  err_r;
    logic                  wlast_err_r;
    logic [1:0]            bresp_r;

    logic [ADDR_WIDTH-1:0] cur_addr_s;
    logic [ADDR_WIDTH-1:0] next_addr_s;
    logic [LEN_WIDTH-1:0]  cur_len_s;
    logic                  illegal_s;
    logic                  wready_s;
    logic                  beat_fire_s;
    logic                  burst_end_s;
    logic                  last_s;
    logic                  wlast_bad_s;
    logic                  unused_s;

    assign cur_addr_s = aw_r.addr[ADDR_WIDTH-1:0];
    assign cur_len_s  = aw_r.len[LEN_WIDTH-1:0];
    // Descriptor bits above the configured widths carry no information
    assign unused_s   = ^{aw_r, cnt_r};

    assign illegal_s = (awsize > MAX_SIZE) || (awburst == 2'b11) ||
                       ((awburst == 2'b10) && !wrap_len_ok(MAX_LEN_WIDTH'(awlen)));

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_addr_gen (
        .addr      (cur_addr_s),
        .size      (aw_r.size),
        .len       (cur_len_s),
        .burst     (aw_r.burst),
        .next_addr (next_addr_s)
    );

    assign beat_fire_s = (state_r == S_DATA) && wvalid && wready_s;

`ifdef SLAVE_AXI_WLAST_CHECK_EN
    logic final_beat_s;
    assign final_beat_s = (cnt_r == cur_len_s);
    assign last_s       = final_beat_s;
    assign burst_end_s  = beat_fire_s && final_beat_s;
    assign wlast_bad_s  = beat_fire_s && (wlast != final_beat_s);
`else
    assign last_s       = wlast;
    assign burst_end_s  = beat_fire_s && wlast;
    assign wlast_bad_s  = 1'b0;
`endif

    assign wready    = wready_s;
    assign beat_data = wdata;
    assign beat_strb = wstrb;
    assign beat_addr = cur_addr_s;
    assign bid       = aw_r.id[ID_WIDTH-1:0];
    assign bresp     = bresp_r;

    // Next-state and handshake decode; erroneous bursts drain W without the engine
    always_comb begin
        state_nxt_s    = state_r;
        awready        = 1'b0;
        wready_s       = 1'b0;
        beat_valid     = 1'b0;
        beat_last      = 1'b0;
        eng_resp_ready = 1'b0;
        bvalid         = 1'b0;
        case (state_r)
            S_IDLE: begin
                awready = 1'b1;
                if (awvalid) begin
                    state_nxt_s = S_DATA;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_DATA: begin
                beat_last = last_s;
                if (err_r) begin
                    wready_s = 1'b1;
                end else begin
                    beat_valid = wvalid;
                    wready_s   = beat_ready;
                end
                if (burst_end_s) begin
                    state_nxt_s = err_r ? S_B : S_RESP_WAIT;
                end else begin
                    state_nxt_s = S_DATA;
                end
            end
            S_RESP_WAIT: begin
                eng_resp_ready = 1'b1;
                if (eng_resp_valid) begin
                    state_nxt_s = S_B;
                end else begin
                    state_nxt_s = S_RESP_WAIT;
                end
            end
            S_B: begin
                bvalid = 1'b1;
                if (bready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_B;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register plus burst descriptor, beat counter, error flags and response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            aw_r        <= '0;
            cnt_r       <= '0;
            err_r       <= 1'b0;
            wlast_err_r <= 1'b0;
            bresp_r     <= RESP_OKAY;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                S_IDLE: begin
                    if (awvalid) begin
                        aw_r.id     <= MAX_ID_WIDTH'(awid);
                        aw_r.addr   <= MAX_ADDR_WIDTH'(awaddr);
                        aw_r.len    <= MAX_LEN_WIDTH'(awlen);
                        aw_r.size   <= awsize;
                        aw_r.burst  <= burst_t'(awburst);
                        cnt_r       <= '0;
                        err_r       <= illegal_s;
                        wlast_err_r <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (beat_fire_s) begin
                        cnt_r     <= cnt_r + LEN_WIDTH'(1'b1);
                        aw_r.addr <= MAX_ADDR_WIDTH'(next_addr_s);
                        if (wlast_bad_s) begin
                            wlast_err_r <= 1'b1;
                        end
                        if (burst_end_s && err_r) begin
                            bresp_r <= RESP_SLVERR;
                        end
                    end
                end
                S_RESP_WAIT: begin
                    if (eng_resp_valid) begin
                        bresp_r <= wlast_err_r ? RESP_SLVERR : eng_resp;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_slave_axi_write_slave.sv
// Directed bench for slave_axi_write_slave: INCR/WRAP/FIXED bursts, stalls,
// illegal-size drain, engine error with B backpressure and mid-burst reset.
module tb_slave_axi_write_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic        beat_valid, beat_ready;
    logic [31:0] beat_addr, beat_data;
    logic [3:0]  beat_strb;
    logic        beat_last;
    logic        eng_resp_valid, eng_resp_ready;
    logic [1:0]  eng_resp;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic        q_last[$];
    int          bv_cnt = 0;
    int          er_cnt = 0;

    always #5 clk = ~clk;

    slave_axi_write_slave dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
        .beat_data(beat_data), .beat_strb(beat_strb), .beat_last(beat_last),
        .eng_resp_valid(eng_resp_valid), .eng_resp_ready(eng_resp_ready), .eng_resp(eng_resp)
    );

    // Beat and ready observer, sampled mid-cycle
    always @(negedge clk) begin
        if (beat_valid && beat_ready) begin
            q_addr.push_back(beat_addr);
            q_data.push_back(beat_data);
            q_last.push_back(beat_last);
        end
        if (beat_valid) bv_cnt++;
        if (eng_resp_ready) er_cnt++;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (!awready && n < 20) begin @(posedge clk); #1; n++; end
        check_val("aw_ready", awready, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic last, input int stall);
        int n = 0;
        wdata = d; wstrb = 4'hF; wlast = last; wvalid = 1'b1;
        beat_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            #1;
            check_val("stall_wready", wready, 1'b0);
            @(posedge clk); #1;
        end
        beat_ready = 1'b1;
        #1;
        while (!wready && n < 20) begin @(posedge clk); #1; n++; end
        check_val("w_accept", wready, 1'b1);
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic do_eng(input logic [1:0] code, input int delay);
        int n = 0;
        for (int i = 0; i < delay; i++) begin @(posedge clk); #1; end
        eng_resp = code; eng_resp_valid = 1'b1;
        while (!eng_resp_ready && n < 20) begin @(posedge clk); #1; n++; end
        check_val("eng_ready", eng_resp_ready, 1'b1);
        @(posedge clk); #1;
        eng_resp_valid = 1'b0;
    endtask

    task automatic check_b(input string tag, input logic [1:0] exp_resp, input logic [3:0] exp_id,
                           input int hold);
        int n = 0;
        bready = 1'b0;
        while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
        check_val({tag, "_bvalid"}, bvalid, 1'b1);
        check_val({tag, "_bresp"}, bresp, exp_resp);
        check_val({tag, "_bid"}, bid, exp_id);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val({tag, "_hold_bvalid"}, bvalid, 1'b1);
            check_val({tag, "_hold_bresp"}, bresp, exp_resp);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check_val({tag, "_bdone"}, bvalid, 1'b0);
        check_val({tag, "_awready_after"}, awready, 1'b1);
    endtask

    task automatic check_burst(input string tag, input int base, input int n,
                               input logic [127:0] addrs, input logic [127:0] datas,
                               input logic [3:0] lasts);
        check_val({tag, "_count"}, q_addr.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < q_addr.size()) begin
                check_val({tag, "_addr"}, q_addr[base+i], addrs[32*i +: 32]);
                check_val({tag, "_data"}, q_data[base+i], datas[32*i +: 32]);
                check_val({tag, "_last"}, q_last[base+i], lasts[i]);
            end
        end
    endtask

    initial begin
        int base, bv0, er0;
        rst_n = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; beat_ready = 1'b1;
        eng_resp_valid = 1'b0; eng_resp = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_awready", awready, 1'b1);
        check_val("rst_wready", wready, 1'b0);
        check_val("rst_bvalid", bvalid, 1'b0);
        check_val("rst_beat_valid", beat_valid, 1'b0);
        check_val("rst_beat_last", beat_last, 1'b0);
        check_val("rst_eng_ready", eng_resp_ready, 1'b0);
        check_val("rst_bid", bid, 4'h0);
        check_val("rst_bresp", bresp, 2'b00);
        check_val("rst_beat_addr", beat_addr, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // INCR, 4 beats of 4 bytes
        base = q_addr.size();
        do_aw(4'h5, 32'h0000_1000, 4'd3, 3'd2, 2'b01);
        do_w(32'hA0, 1'b0, 0); do_w(32'hA1, 1'b0, 0); do_w(32'hA2, 1'b0, 0); do_w(32'hA3, 1'b1, 0);
        do_eng(2'b00, 0);
        check_b("incr", 2'b00, 4'h5, 0);
        check_burst("incr", base, 4, {32'h100C, 32'h1008, 32'h1004, 32'h1000},
                    {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'b1000);

        // WRAP inside a 16-byte window
        base = q_addr.size();
        do_aw(4'h3, 32'h0000_2038, 4'd3, 3'd2, 2'b10);
        do_w(32'hB0, 1'b0, 0); do_w(32'hB1, 1'b0, 0); do_w(32'hB2, 1'b0, 0); do_w(32'hB3, 1'b1, 0);
        do_eng(2'b00, 0);
        check_b("wrap", 2'b00, 4'h3, 0);
        check_burst("wrap", base, 4, {32'h2034, 32'h2030, 32'h203C, 32'h2038},
                    {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4'b1000);

        // FIXED with engine stall on beat 2
        base = q_addr.size();
        do_aw(4'hC, 32'h0000_3000, 4'd2, 3'd2, 2'b00);
        do_w(32'hC0, 1'b0, 0); do_w(32'hC1, 1'b0, 2); do_w(32'hC2, 1'b1, 0);
        do_eng(2'b00, 0);
        check_b("fixed", 2'b00, 4'hC, 0);
        check_burst("fixed", base, 3, {32'h0, 32'h3000, 32'h3000, 32'h3000},
                    {32'h0, 32'hC2, 32'hC1, 32'hC0}, 4'b0100);

        // Oversized beat: drained locally, SLVERR without engine involvement
        base = q_addr.size(); bv0 = bv_cnt; er0 = er_cnt;
        do_aw(4'h9, 32'h0000_4000, 4'd1, 3'd3, 2'b01);
        do_w(32'hD0, 1'b0, 0); do_w(32'hD1, 1'b1, 0);
        check_b("illegal", 2'b10, 4'h9, 0);
        check_val("illegal_beat_valid", bv_cnt - bv0, 0);
        check_val("illegal_eng_ready", er_cnt - er0, 0);
        check_val("illegal_beats", q_addr.size() - base, 0);

        // Slow engine error, B backpressure
        do_aw(4'hA, 32'h0000_5000, 4'd0, 3'd2, 2'b01);
        do_w(32'hE0, 1'b1, 0);
        check_val("resp_wait_ready", eng_resp_ready, 1'b1);
        do_eng(2'b10, 5);
        check_b("engerr", 2'b10, 4'hA, 3);

`ifdef SLAVE_AXI_WLAST_CHECK_EN
        // Early WLAST: still len+1 beats forwarded, last flagged by count
        base = q_addr.size();
        do_aw(4'h7, 32'h0000_7000, 4'd3, 3'd2, 2'b01);
        do_w(32'hF0, 1'b0, 0); do_w(32'hF1, 1'b1, 0); do_w(32'hF2, 1'b0, 0); do_w(32'hF3, 1'b0, 0);
        do_eng(2'b00, 0);
        check_b("wlastchk", 2'b10, 4'h7, 0);
        check_burst("wlastchk", base, 4, {32'h700C, 32'h7008, 32'h7004, 32'h7000},
                    {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 4'b1000);
`endif

        // Reset in the middle of a burst
        do_aw(4'h6, 32'h0000_6000, 4'd3, 3'd2, 2'b01);
        do_w(32'h60, 1'b0, 0);
        wdata = 32'h61; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        check_val("mrst_awready", awready, 1'b1);
        check_val("mrst_wready", wready, 1'b0);
        check_val("mrst_beat_valid", beat_valid, 1'b0);
        check_val("mrst_beat_last", beat_last, 1'b0);
        check_val("mrst_beat_addr", beat_addr, 32'h0);
        check_val("mrst_bvalid", bvalid, 1'b0);
        check_val("mrst_bid", bid, 4'h0);
        check_val("mrst_bresp", bresp, 2'b00);
        check_val("mrst_eng_ready", eng_resp_ready, 1'b0);
        wvalid = 1'b0; wlast = 1'b0; rst_n = 1'b1;
        base = q_addr.size();
        repeat (4) @(posedge clk);
        #1;
        check_val("mrst_no_b", bvalid, 1'b0);
        check_val("mrst_no_beats", q_addr.size() - base, 0);

        // Recovery burst after reset
        base = q_addr.size();
        do_aw(4'h1, 32'h0000_0100, 4'd0, 3'd2, 2'b01);
        do_w(32'h11, 1'b1, 0);
        do_eng(2'b00, 0);
        check_b("recover", 2'b00, 4'h1, 0);
        check_burst("recover", base, 1, {32'h0, 32'h0, 32'h0, 32'h0100},
                    {32'h0, 32'h0, 32'h0, 32'h11}, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
